word_scheduler: RTL and testbench
=================================

WORD_SCHEDULER -- requirements
Module: word_scheduler

Interface
REQ-001 SHALL have parameter MAX_NOTES, default 8, meaning the maximum number of non-terminator notes forwarded per word.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the cycles allowed in WAIT_DONE; used only with WORD_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports Req0_valid, Req0_tom (1 bit) and Req0_nota (3 bits), all inputs: note stream from requester 0.
REQ-006 SHALL have port Req0_ready, output, 1 bit: note accepted from requester 0.
REQ-007 SHALL have ports Req1_valid, Req1_tom, Req1_nota and Req1_ready, identical to REQ-005/006: requester 1.
REQ-008 SHALL have port Cls_start, output, 1 bit: pulse that clears the classifier's word state.
REQ-009 SHALL have ports Cls_valid, Cls_tom (1 bit) and Cls_nota (3 bits), all outputs: note presented to the classifier.
REQ-010 SHALL have ports Cls_done (input, 1 bit) and Cls_tipo (input, 2 bits): classifier result.
REQ-011 SHALL have ports Res_valid, Res_src, Res_ovf and Res_err (outputs, 1 bit each) and Res_tipo (output, 2 bits): word result.
REQ-012 SHALL have port Res_ack, input, 1 bit: result consumed.
REQ-013 SHALL have port Busy, output, 1 bit: state is not IDLE.
REQ-014 SHALL have port Word_cnt, output, 8 bits: number of completed words.

Function
REQ-015 SHALL implement the states IDLE, STREAM, INJECT, WAIT_DONE and RESULT.
REQ-016 SHALL, in IDLE with any Reqx_valid=1, grant one requester, pulse Cls_start for that one cycle, and enter STREAM on the next cycle.
REQ-017 SHALL resolve both valid in IDLE by a priority pointer: the pointed requester wins, and the pointer moves to the other requester when Res_ack completes a word.
REQ-018 SHALL, in STREAM, drive Reqg_ready=1 for the granted requester and 0 for the other, and pass Cls_valid, Cls_tom and Cls_nota combinationally from the granted channel.
REQ-019 SHALL treat a note with nota=000 (either tom) as the word terminator.
REQ-020 SHALL, when the terminator is accepted, forward it and enter WAIT_DONE on the next cycle.
REQ-021 SHALL count non-terminator notes accepted; when the count reaches MAX_NOTES without a terminator, enter INJECT.
REQ-022 SHALL, in INJECT, drive Reqg_ready=0 and Cls_valid=1 with Cls_tom=0 and Cls_nota=000 for one cycle, set the overflow flag, and enter WAIT_DONE.
REQ-023 SHALL treat further notes from that requester after an injection as the start of a new word.
REQ-024 SHALL sample Cls_done only in WAIT_DONE; on Cls_done=1, register Cls_tipo into Res_tipo and enter RESULT.
REQ-025 SHALL ignore Cls_done in every other state, including the terminator-accept cycle.
REQ-026 SHALL, in RESULT, hold Res_valid=1 and hold Res_tipo, Res_src (granted index), Res_ovf and Res_err stable until Res_ack=1.
REQ-027 SHALL, on Res_ack=1 in RESULT, deassert Res_valid the next cycle, increment Word_cnt (255 wraps to 0), clear the note count and flags, and enter IDLE.
REQ-028 SHALL ignore Res_ack outside RESULT.
REQ-029 SHALL drive Cls_valid=0 and both Reqx_ready=0 in IDLE, WAIT_DONE and RESULT.
REQ-030 SHALL drive Busy combinationally as (state != IDLE).

Reset
REQ-031 SHALL, while Reset=1 at a clk edge, enter IDLE, set the pointer to requester 0, and clear Word_cnt, the note count, Res_valid, Res_tipo, Res_src, Res_ovf and Res_err.
REQ-032 SHALL hold Cls_start, Cls_valid, Cls_tom, Cls_nota and both Reqx_ready at 0 while Reset=1.
REQ-033 SHALL, on Reset during any state, abandon the in-flight word and produce no result for it.

Configuration
REQ-034 SHALL, with WORD_TIMEOUT_EN defined, count cycles in WAIT_DONE and, after TIMEOUT cycles without Cls_done, enter RESULT with Res_tipo=00 and Res_err=1.
REQ-035 SHALL, with WORD_TIMEOUT_EN undefined, wait in WAIT_DONE indefinitely and tie Res_err to 0.

Verification
REQ-036 SHALL cover single word: Req0 sends (0,011), then (0,000); Cls_done=1 with tipo=11 two cycles later -> Res_valid=1, Res_tipo=11, Res_src=0, Word_cnt=1 after ack.
REQ-037 SHALL cover contention: Req0 and Req1 both valid in IDLE after reset -> Req0 served first; after its ack, Req1 is granted with Cls_start pulsed once.
REQ-038 SHALL cover overflow: Req1 sends 9 notes of (0,100) with no terminator -> 8 forwarded, injected (0,000) seen, Res_ovf=1, and the 9th note begins the next word.
REQ-039 SHALL cover stray done: Cls_done=1 in the same cycle the terminator is accepted -> ignored; the result appears only on a later Cls_done.
REQ-040 SHALL cover reset mid-STREAM: Reset during the third note -> Busy=0, Res_valid=0, Word_cnt unchanged at 0.
REQ-041 SHALL cover timeout with WORD_TIMEOUT_EN: no Cls_done for 16 cycles -> Res_valid=1, Res_tipo=00, Res_err=1.

Source files
------------

// File: rtl/word_scheduler.sv
// word_scheduler: grants one of two note streams to a shared classifier, one word at a time.
// Optional build macro WORD_TIMEOUT_EN bounds the wait for Cls_done and reports Res_err on expiry.
module word_scheduler #(
    parameter int MAX_NOTES = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Req0_valid,
    input  logic       Req0_tom,
    input  logic [2:0] Req0_nota,
    output logic       Req0_ready,
    input  logic       Req1_valid,
    input  logic       Req1_tom,
    input  logic [2:0] Req1_nota,
    output logic       Req1_ready,
    output logic       Cls_start,
    output logic       Cls_valid,
    output logic       Cls_tom,
    output logic [2:0] Cls_nota,
    input  logic       Cls_done,
    input  logic [1:0] Cls_tipo,
    output logic       Res_valid,
    output logic       Res_src,
    output logic       Res_ovf,
    output logic       Res_err,
    output logic [1:0] Res_tipo,
    input  logic       Res_ack,
    output logic       Busy,
    output logic [7:0] Word_cnt
);
    localparam int CW = $clog2(MAX_NOTES + 1);

    if (MAX_NOTES < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("word_scheduler: MAX_NOTES and TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, STREAM, INJECT, WAIT_DONE, RESULT} state_t;

    state_t         state_q;
    logic           ptr_q;
    logic           grant_q;
    logic [CW-1:0]  cnt_q;
    logic [7:0]     word_cnt_q;
    logic           res_valid_q;
    logic [1:0]     res_tipo_q;
    logic           res_ovf_q;

    logic           any_valid;
    logic           winner;
    logic           g_valid;
    logic           g_tom;
    logic [2:0]     g_nota;
    logic           in_stream;

    assign any_valid = Req0_valid | Req1_valid;
    // Pointer only matters when both requesters are valid at once.
    assign winner    = (Req0_valid & Req1_valid) ? ptr_q : Req1_valid;
    assign g_valid   = grant_q ? Req1_valid : Req0_valid;
    assign g_tom     = grant_q ? Req1_tom   : Req0_tom;
    assign g_nota    = grant_q ? Req1_nota  : Req0_nota;
    assign in_stream = (state_q == STREAM) & ~Reset;

    assign Req0_ready = in_stream & ~grant_q;
    assign Req1_ready = in_stream &  grant_q;
    assign Cls_start  = (state_q == IDLE) & any_valid & ~Reset;
    assign Busy       = (state_q != IDLE);

    always_comb begin
        Cls_valid = 1'b0;
        Cls_tom   = 1'b0;
        Cls_nota  = 3'b000;
        if (in_stream) begin
            Cls_valid = g_valid;
            Cls_tom   = g_tom;
            Cls_nota  = g_nota;
        end else if ((state_q == INJECT) && !Reset) begin
            Cls_valid = 1'b1;
        end
    end

`ifdef WORD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          res_err_q;
    assign Res_err = res_err_q;
`else
    assign Res_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            grant_q     <= 1'b0;
            cnt_q       <= '0;
            word_cnt_q  <= 8'd0;
            res_valid_q <= 1'b0;
            res_tipo_q  <= 2'b00;
            res_ovf_q   <= 1'b0;
`ifdef WORD_TIMEOUT_EN
            tmo_q       <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
`ifdef WORD_TIMEOUT_EN
            if (state_q != WAIT_DONE) tmo_q <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        grant_q <= winner;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (g_valid) begin
                        if (g_nota == 3'b000) begin
                            state_q <= WAIT_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CW'(MAX_NOTES - 1)) state_q <= INJECT;
                        end
                    end
                end
                INJECT: begin
                    res_ovf_q <= 1'b1;
                    state_q   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (Cls_done) begin
                        res_tipo_q  <= Cls_tipo;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
`ifdef WORD_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        res_tipo_q  <= 2'b00;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                RESULT: begin
                    if (Res_ack) begin
                        res_valid_q <= 1'b0;
                        word_cnt_q  <= word_cnt_q + 8'd1;
                        cnt_q       <= '0;
                        res_ovf_q   <= 1'b0;
`ifdef WORD_TIMEOUT_EN
                        res_err_q   <= 1'b0;
`endif
                        ptr_q       <= ~ptr_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Res_valid = res_valid_q;
    assign Res_tipo  = res_tipo_q;
    assign Res_src   = grant_q;
    assign Res_ovf   = res_ovf_q;
    assign Word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_word_scheduler.sv
// Randomized bench for word_scheduler: notes are queued per requester and each word is
// predicted by parsing those queues (terminator or MAX_NOTES cut) plus a round-robin pointer.
module tb_word_scheduler;
    localparam int MAX_NOTES = 8;
    localparam int TIMEOUT   = 16;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Req0_valid, Req0_tom, Req0_ready;
    logic [2:0] Req0_nota;
    logic       Req1_valid, Req1_tom, Req1_ready;
    logic [2:0] Req1_nota;
    logic       Cls_start, Cls_valid, Cls_tom;
    logic [2:0] Cls_nota;
    logic       Cls_done;
    logic [1:0] Cls_tipo;
    logic       Res_valid, Res_src, Res_ovf, Res_err;
    logic [1:0] Res_tipo;
    logic       Res_ack;
    logic       Busy;
    logic [7:0] Word_cnt;

    always #5 clk = ~clk;

    word_scheduler #(.MAX_NOTES(MAX_NOTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .Reset(Reset),
        .Req0_valid(Req0_valid), .Req0_tom(Req0_tom), .Req0_nota(Req0_nota), .Req0_ready(Req0_ready),
        .Req1_valid(Req1_valid), .Req1_tom(Req1_tom), .Req1_nota(Req1_nota), .Req1_ready(Req1_ready),
        .Cls_start(Cls_start), .Cls_valid(Cls_valid), .Cls_tom(Cls_tom), .Cls_nota(Cls_nota),
        .Cls_done(Cls_done), .Cls_tipo(Cls_tipo),
        .Res_valid(Res_valid), .Res_src(Res_src), .Res_ovf(Res_ovf), .Res_err(Res_err),
        .Res_tipo(Res_tipo), .Res_ack(Res_ack), .Busy(Busy), .Word_cnt(Word_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Notes are {tom, nota}; nota == 0 is the word terminator.
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] exp_notes[$];
    int         exp_ptr   = 0;
    int         exp_words = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs(input bit gaps);
        Req0_valid = (q0.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        Req1_valid = (q1.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        {Req0_tom, Req0_nota} = 4'h0;
        {Req1_tom, Req1_nota} = 4'h0;
        if (q0.size() > 0) {Req0_tom, Req0_nota} = q0[0];
        if (q1.size() > 0) {Req1_tom, Req1_nota} = q1[0];
    endtask

    // Called after sampling; moves to the next negedge and retires accepted notes.
    task automatic advance();
        bit a0, a1;
        a0 = Req0_valid & Req0_ready;
        a1 = Req1_valid & Req1_ready;
        @(negedge clk);
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
    endtask

    task automatic run_word(input bit gaps, input bit force_stray, input int tipo_in, input bit no_done);
        int         w;
        int         nt;
        int         cyc;
        int         d;
        int         h;
        bit         ovf;
        bit         term;
        bit         inj;
        logic [1:0] tipo;
        logic [1:0] exp_tipo;
        logic [3:0] sq[$];
        logic [3:0] obs[$];

        tipo = (tipo_in < 0) ? 2'($urandom_range(0, 3)) : 2'(tipo_in);
        Cls_done = 1'b0;
        Res_ack  = 1'b0;

        drive_reqs(1'b0);
        #1;
        check_eq("idle_busy", Busy, 0);
        check_eq("idle_start", Cls_start, 1);
        w = (Req0_valid && Req1_valid) ? exp_ptr : (Req1_valid ? 1 : 0);
        sq = (w == 1) ? q1 : q0;
        exp_notes.delete();
        ovf = 0;
        nt  = 0;
        for (int i = 0; i < sq.size(); i++) begin
            exp_notes.push_back(sq[i]);
            if (sq[i][2:0] == 3'b000) break;
            nt++;
            if (nt == MAX_NOTES) begin
                exp_notes.push_back(4'h0);
                ovf = 1;
                break;
            end
        end
        advance();

        obs.delete();
        cyc = 0;
        forever begin
            drive_reqs(gaps);
            #1;
            inj = ovf && (obs.size() == MAX_NOTES);
            check_eq("stream_start", Cls_start, 0);
            check_eq("stream_busy", Busy, 1);
            check_eq("rdy_grant", (w == 1) ? Req1_ready : Req0_ready, !inj);
            check_eq("rdy_other", (w == 1) ? Req0_ready : Req1_ready, 0);
            if (Cls_valid) obs.push_back({Cls_tom, Cls_nota});
            term = Cls_valid && (Cls_nota == 3'b000);
            if (term && force_stray) begin
                Cls_done = 1'b1;
                Cls_tipo = ~tipo;
            end
            advance();
            Cls_done = 1'b0;
            if (term) break;
            cyc++;
            if (cyc > 60) begin
                check_eq("term_seen", obs.size(), exp_notes.size() + 1);
                return;
            end
        end
        check_eq("n_notes", obs.size(), exp_notes.size());
        for (int i = 0; i < obs.size() && i < exp_notes.size(); i++)
            check_eq($sformatf("note%0d", i), obs[i], exp_notes[i]);

        if (no_done) begin
            cyc = 0;
            forever begin
                drive_reqs(gaps);
                #1;
                if (Res_valid) break;
                cyc++;
                advance();
                if (cyc > TIMEOUT + 4) break;
            end
            check_eq("tmo_cycles", cyc, TIMEOUT);
            exp_tipo = 2'b00;
        end else begin
            d = force_stray ? $urandom_range(1, 3) : $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                drive_reqs(gaps);
                Res_ack = 1'($urandom_range(0, 1));
                #1;
                check_eq("wait_rv", Res_valid, 0);
                check_eq("wait_clsv", Cls_valid, 0);
                check_eq("wait_rdy", Req0_ready | Req1_ready, 0);
                advance();
            end
            Res_ack = 1'b0;
            drive_reqs(gaps);
            Cls_done = 1'b1;
            Cls_tipo = tipo;
            #1;
            check_eq("done_rv", Res_valid, 0);
            advance();
            Cls_done = 1'b0;
            Cls_tipo = 2'($urandom_range(0, 3));
            exp_tipo = tipo;
        end

        h = $urandom_range(0, 2);
        for (int i = 0; i <= h; i++) begin
            drive_reqs(gaps);
            Cls_done = 1'($urandom_range(0, 1));
            Res_ack  = (i == h);
            #1;
            check_eq("res_valid", Res_valid, 1);
            check_eq("res_tipo", Res_tipo, exp_tipo);
            check_eq("res_src", Res_src, w);
            check_eq("res_ovf", Res_ovf, ovf);
            check_eq("res_err", Res_err, no_done);
            check_eq("res_rdy", Req0_ready | Req1_ready | Cls_valid, 0);
            check_eq("res_cnt", Word_cnt, exp_words);
            advance();
        end
        Res_ack  = 1'b0;
        Cls_done = 1'b0;
        exp_words = (exp_words + 1) % 256;
        exp_ptr   = 1 - exp_ptr;
        drive_reqs(1'b0);
        #1;
        check_eq("ack_rv", Res_valid, 0);
        check_eq("ack_busy", Busy, 0);
        check_eq("ack_cnt", Word_cnt, exp_words);
        $display("word %0d src=%0d notes=%0d ovf=%0d tipo=%0d", exp_words, w, obs.size(), ovf, exp_tipo);
    endtask

    initial begin
        Reset = 1'b1;
        Cls_done = 1'b0;
        Cls_tipo = 2'b00;
        Res_ack  = 1'b0;
        q0 = '{4'h1, 4'h2, 4'hD, 4'h0};
        drive_reqs(1'b0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_start", Cls_start, 0);
        check_eq("rst_rdy", Req0_ready | Req1_ready | Cls_valid, 0);
        check_eq("rst_busy", Busy, 0);
        check_eq("rst_rv", Res_valid, 0);
        check_eq("rst_cnt", Word_cnt, 0);
        check_eq("rst_res", {Res_tipo, Res_src, Res_ovf, Res_err}, 0);
        @(negedge clk);
        Reset = 1'b0;

        // Reset while the third note is presented abandons the word.
        for (int i = 0; i < 3; i++) begin
            drive_reqs(1'b0);
            #1;
            advance();
        end
        drive_reqs(1'b0);
        Reset = 1'b1;
        #1;
        check_eq("midrst_clsv", Cls_valid, 0);
        check_eq("midrst_rdy", Req0_ready | Req1_ready | Cls_start, 0);
        advance();
        Reset = 1'b0;
        q0.delete();
        drive_reqs(1'b0);
        #1;
        check_eq("midrst_busy", Busy, 0);
        check_eq("midrst_rv", Res_valid, 0);
        check_eq("midrst_cnt", Word_cnt, 0);
        $display("reset mid-stream: busy=%0d cnt=%0d", Busy, Word_cnt);
        @(negedge clk);

        // Contention, overflow and a stray done on the terminator cycle.
        q0 = '{4'h3, 4'h0};
        q1 = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
        run_word(1'b0, 1'b1, 3, 1'b0);
        run_word(1'b0, 1'b0, -1, 1'b0);
        run_word(1'b0, 1'b1, -1, 1'b0);

        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 6; k++) begin
                int len;
                len = $urandom_range(0, 9);
                for (int j = 0; j < len; j++) begin
                    if (r == 0) q0.push_back({1'($urandom_range(0, 1)), 3'($urandom_range(1, 7))});
                    else        q1.push_back({1'($urandom_range(0, 1)), 3'($urandom_range(1, 7))});
                end
                if (len < MAX_NOTES) begin
                    if (r == 0) q0.push_back({1'($urandom_range(0, 1)), 3'b000});
                    else        q1.push_back({1'($urandom_range(0, 1)), 3'b000});
                end
            end
        end
        q0.push_back(4'h8);
        q1.push_back(4'h0);
        for (int g = 0; g < 100 && (q0.size() > 0 || q1.size() > 0); g++)
            run_word(1'b1, 1'($urandom_range(0, 1)), -1, 1'b0);

`ifdef WORD_TIMEOUT_EN
        q0 = '{4'hA, 4'h0};
        run_word(1'b0, 1'b0, -1, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
